// File: rtl/sig_control.sv
// sig_control: highway/country-road traffic-light Moore FSM with programmable
// yellow and all-red phase lengths.
module sig_control #(
    parameter int Y2RDELAY = 3,
    parameter int R2GDELAY = 2,
    parameter int CNT_W    = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       x,
    output logic [1:0] hwy,
    output logic [1:0] cntry
);
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [1:0] GREEN  = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] RED    = 2'd2;
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y2RDELAY - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R2GDELAY - 1);

    logic [2:0]       state, nxt;
    logic [CNT_W-1:0] timer;
    logic             timed;

    always_comb begin
        nxt = S0;
        case (state)
            S0: nxt = x ? S1 : S0;
            S1: nxt = (timer == Y_LAST) ? S2 : S1;
            S2: nxt = (timer == R_LAST) ? S3 : S2;
            S3: nxt = x ? S3 : S4;
            S4: nxt = (timer == Y_LAST) ? S0 : S4;
            default: nxt = S0;
        endcase
    end

    assign timed = (state == S1) || (state == S2) || (state == S4);

    // Timer restarts on every state change, so each timed phase starts from 0.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S0;
            timer <= '0;
        end else begin
            state <= nxt;
            timer <= (nxt != state || !timed) ? '0 : timer + 1'b1;
        end
    end

    assign hwy   = (state == S0) ? GREEN : (state == S1) ? YELLOW : RED;
    assign cntry = (state == S3) ? GREEN : (state == S4) ? YELLOW : RED;
endmodule

// File: tb/tb_sig_control.sv
// tb_sig_control: directed stimulus with a countdown-based reference model
// feeding an expected-output queue checked after each rising edge.
module tb_sig_control;
    localparam int Y2R = 3;
    localparam int R2G = 2;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       x     = 1'b0;
    logic [1:0] hwy, cntry;

    int checks = 0;
    int errors = 0;
    int ms     = 0;
    int rem    = 0;
    int nstep  = 0;
    logic [3:0] q[$];
    logic [1:0] hexp[5] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
    logic [1:0] cexp[5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1};

    sig_control #(.Y2RDELAY(Y2R), .R2GDELAY(R2G), .CNT_W(8)) dut (
        .clock(clock),
        .clear(clear),
        .x(x),
        .hwy(hwy),
        .cntry(cntry)
    );

    always #5 clock = ~clock;

    task automatic step(input logic c, input logic xi, input logic glitch);
        logic [3:0] e;
        logic       ok;
        @(negedge clock);
        clear = c;
        x = xi;
        if (glitch) begin
            #1 x = 1'b1;
            #2 x = 1'b0;
        end
        if (c) begin
            ms = 0;
            rem = 0;
        end else begin
            case (ms)
                0: if (xi) begin ms = 1; rem = Y2R; end
                1: if (rem == 1) begin ms = 2; rem = R2G; end else rem--;
                2: if (rem == 1) ms = 3; else rem--;
                3: if (!xi) begin ms = 4; rem = Y2R; end
                4: if (rem == 1) ms = 0; else rem--;
                default: ms = 0;
            endcase
        end
        q.push_back({hexp[ms], cexp[ms]});
        @(posedge clock);
        #1;
        nstep++;
        e = q.pop_front();
        checks++;
        assert ({hwy, cntry} === e) else begin
            errors++;
            $error("FAIL lights step%0d got hwy=%b cntry=%b exp hwy=%b cntry=%b",
                   nstep, hwy, cntry, e[3:2], e[1:0]);
        end
        ok = (hwy == 2'd2) || (cntry == 2'd2);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL overlap step%0d got hwy=%b cntry=%b exp one RED", nstep, hwy, cntry);
        end
    endtask

    initial begin
        repeat (5) step(1'b1, 1'b0, 1'b0);
        repeat (15) step(1'b0, 1'b0, 1'b0);
        repeat (3) begin
            repeat (10) step(1'b0, 1'b1, 1'b0);
            repeat (20) step(1'b0, 1'b0, 1'b0);
        end
        // x pulses that miss every edge must be ignored
        repeat (4) step(1'b0, 1'b0, 1'b1);
        // clear during the all-red phase
        repeat (4) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        // x toggling through S1/S2, dropping at S3, toggling through S4
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        // clear mid-S1 and mid-S4
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
